// File: rtl/bank_cmd_arbiter_pkg.sv
// Shared definitions for the bank command arbiter.
// Holds the {cas,ras,we} command encodings used by the bank machines, the
// refresher and the output slot, the default DRAM timing spacing values and a
// small helper that recognises an ACTIVATE.
package bank_cmd_arbiter_pkg;

   // Command encodings as {cas, ras, we}, 1 = asserted.
   typedef enum logic [2:0] {
      CMD_NOP = 3'b000,
      CMD_ACT = 3'b010,
      CMD_PRE = 3'b011,
      CMD_RD  = 3'b100,
      CMD_WR  = 3'b101,
      CMD_REF = 3'b110
   } cmd_e;

   // Default inter-bank ACTIVATE spacing, in cycles.
   localparam int DEFAULT_TRRD = 2;
   localparam int DEFAULT_TFAW = 8;

   // An ACTIVATE is ras asserted with cas and we both deasserted.
   function automatic logic is_act(input logic cas, input logic ras, input logic we);
      return ({cas, ras, we} == CMD_ACT);
   endfunction

endpackage

// File: rtl/bank_cmd_arbiter_if.sv
// Command bus between the per-bank machines / refresher and the arbiter.
// Ports:
//   bm_*   per-bank command streams (valid/ready handshake, address, encoding, class)
//   ref_*  refresher command stream (valid/ready handshake, address, encoding)
//   out_*  registered single DRAM command slot
// Modports:
//   master  the command sources and slot consumer
//   slave   the arbiter
interface bank_cmd_arbiter_if #(
   parameter int NBANKS = 8,
   parameter int ABITS  = 14,
   parameter int BABITS = 3
);
   logic [NBANKS-1:0]       bm_valid;
   logic [NBANKS-1:0]       bm_ready;
   logic [NBANKS*ABITS-1:0] bm_a;
   logic [NBANKS-1:0]       bm_cas;
   logic [NBANKS-1:0]       bm_ras;
   logic [NBANKS-1:0]       bm_we;
   logic [NBANKS-1:0]       bm_is_cmd;
   logic [NBANKS-1:0]       bm_is_read;
   logic [NBANKS-1:0]       bm_is_write;

   logic                    ref_valid;
   logic                    ref_ready;
   logic [ABITS-1:0]        ref_a;
   logic                    ref_cas;
   logic                    ref_ras;
   logic                    ref_we;

   logic                    out_valid;
   logic [ABITS-1:0]        out_a;
   logic [BABITS-1:0]       out_ba;
   logic                    out_cas;
   logic                    out_ras;
   logic                    out_we;
   logic                    out_is_read;
   logic                    out_is_write;

   modport master (
      output bm_valid, bm_a, bm_cas, bm_ras, bm_we, bm_is_cmd, bm_is_read, bm_is_write,
      output ref_valid, ref_a, ref_cas, ref_ras, ref_we,
      input  bm_ready, ref_ready,
      input  out_valid, out_a, out_ba, out_cas, out_ras, out_we, out_is_read, out_is_write
   );

   modport slave (
      input  bm_valid, bm_a, bm_cas, bm_ras, bm_we, bm_is_cmd, bm_is_read, bm_is_write,
      input  ref_valid, ref_a, ref_cas, ref_ras, ref_we,
      output bm_ready, ref_ready,
      output out_valid, out_a, out_ba, out_cas, out_ras, out_we, out_is_read, out_is_write
   );

endinterface

// File: rtl/bank_cmd_arbiter_rr_picker.sv
// Round-robin picker: given a request vector and a start pointer, returns the
// first requesting index found scanning upward from the pointer with wrap.
// Ports:
//   req        in   NBANKS  request per bank
//   ptr        in   IDXW    index where the scan starts (highest priority)
//   grant      out  NBANKS  one-hot grant, zero when nothing requests
//   grant_idx  out  IDXW    binary index of the granted bank
//   grant_any  out  1       some bank was granted
module bank_cmd_arbiter_rr_picker #(
   parameter int NBANKS = 8,
   parameter int IDXW   = 3
) (
   input  logic [NBANKS-1:0] req,
   input  logic [IDXW-1:0]   ptr,
   output logic [NBANKS-1:0] grant,
   output logic [IDXW-1:0]   grant_idx,
   output logic              grant_any
);

   // Walk the banks in priority order ptr, ptr+1, ... wrapping past NBANKS-1,
   // and stop at the first requester. The pointer is always below NBANKS, so
   // a single subtraction is enough to wrap.
   always_comb begin
      int pos;
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      pos       = 0;
      for (int k = 0; k < NBANKS; k++) begin
         pos = int'(ptr) + k;
         if (pos >= NBANKS) begin
            pos = pos - NBANKS;
         end
         for (int j = 0; j < NBANKS; j++) begin
            if (!grant_any && (j == pos) && req[j]) begin
               grant_any = 1'b1;
               grant[j]  = 1'b1;
               grant_idx = IDXW'(j);
            end
         end
      end
   end

endmodule

// File: rtl/bank_cmd_arbiter.sv
// Arbitrates NBANKS bank-machine command streams plus one refresher stream
// onto a single registered DRAM command slot. The refresher has strict
// priority; banks are served round-robin. ACTIVATE spacing between banks is
// held to tRRD and tFAW. The bank address of the slot is the grant index.
// Ports:
//   sys_clk  in  clock
//   sys_rst  in  asynchronous active-high reset
//   bus      slave modport of bank_cmd_arbiter_if (bank/refresher inputs,
//            combinational ready outputs, registered out_* slot)
module bank_cmd_arbiter
   import bank_cmd_arbiter_pkg::*;
#(
   parameter int NBANKS = 8,
   parameter int ABITS  = 14,
   parameter int BABITS = 3,
   parameter int TRRD   = DEFAULT_TRRD,
   parameter int TFAW   = DEFAULT_TFAW
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst,
   bank_cmd_arbiter_if.slave    bus
);

   localparam int TRRD_W = (TRRD > 1) ? $clog2(TRRD) : 1;
   localparam int FAW_CW = $clog2(TFAW + 1);

   logic [NBANKS-1:0] act_vec;
   logic [NBANKS-1:0] eligible;
   logic [NBANKS-1:0] grant;
   logic [BABITS-1:0] grant_idx;
   logic              grant_any;
   logic              bank_acc;
   logic              act_acc;
   logic              act_ok;
   logic [FAW_CW-1:0] faw_cnt;

   logic [ABITS-1:0]  sel_a;
   logic              sel_cas, sel_ras, sel_we, sel_rd, sel_wr;

   logic              out_valid_q, out_valid_d;
   logic [ABITS-1:0]  out_a_q, out_a_d;
   logic [BABITS-1:0] out_ba_q, out_ba_d;
   logic              out_cas_q, out_cas_d;
   logic              out_ras_q, out_ras_d;
   logic              out_we_q, out_we_d;
   logic              out_is_read_q, out_is_read_d;
   logic              out_is_write_q, out_is_write_d;
   logic [BABITS-1:0] rr_ptr_q, rr_ptr_d;
   logic [TRRD_W-1:0] trrd_q, trrd_d;
   logic [TFAW-1:0]   faw_q, faw_d;

   // Work out which banks may be granted this cycle. The ACT count only looks
   // at the newest TFAW-1 history bits: the oldest bit leaves the window at
   // the very edge a new ACT would be registered on, so it no longer counts
   // against that ACT.
   always_comb begin
      act_vec = '0;
      faw_cnt = '0;
      for (int i = 0; i < NBANKS; i++) begin
         act_vec[i] = is_act(bus.bm_cas[i], bus.bm_ras[i], bus.bm_we[i]);
      end
      for (int k = 0; k < TFAW - 1; k++) begin
         faw_cnt = faw_cnt + FAW_CW'(faw_q[k]);
      end
      act_ok   = (trrd_q == '0) && (faw_cnt < FAW_CW'(4));
      eligible = bus.bm_valid & (~act_vec | {NBANKS{act_ok}});
   end

   bank_cmd_arbiter_rr_picker #(
      .NBANKS (NBANKS),
      .IDXW   (BABITS)
   ) u_rr_picker (
      .req       (eligible),
      .ptr       (rr_ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_any (grant_any)
   );

   // The refresher pre-empts the banks outright, so a bank is only accepted
   // when the refresher is idle. Ready is combinational and the slot is never
   // back-pressured, so ready alone means accept.
   assign bank_acc      = grant_any & ~bus.ref_valid;
   assign bus.bm_ready  = bank_acc ? grant : '0;
   assign bus.ref_ready = bus.ref_valid;

   // Pull the granted bank's fields out with a one-hot OR mux.
   always_comb begin
      sel_a   = '0;
      sel_cas = 1'b0;
      sel_ras = 1'b0;
      sel_we  = 1'b0;
      sel_rd  = 1'b0;
      sel_wr  = 1'b0;
      act_acc = 1'b0;
      for (int i = 0; i < NBANKS; i++) begin
         if (grant[i]) begin
            sel_a   = bus.bm_a[i*ABITS +: ABITS];
            sel_cas = bus.bm_cas[i];
            sel_ras = bus.bm_ras[i];
            sel_we  = bus.bm_we[i];
            sel_rd  = bus.bm_is_read[i];
            sel_wr  = bus.bm_is_write[i];
            act_acc = act_vec[i] & bank_acc;
         end
      end
   end

   // Next slot contents and timing state. With nothing accepted the slot
   // becomes a NOP but keeps its last address and bank. Refresher commands
   // do not touch the round-robin pointer or the ACT spacing state.
   always_comb begin
      out_valid_d    = 1'b0;
      out_a_d        = out_a_q;
      out_ba_d       = out_ba_q;
      out_cas_d      = 1'b0;
      out_ras_d      = 1'b0;
      out_we_d       = 1'b0;
      out_is_read_d  = 1'b0;
      out_is_write_d = 1'b0;
      rr_ptr_d       = rr_ptr_q;
      trrd_d         = (trrd_q != '0) ? trrd_q - 1'b1 : '0;
      faw_d          = {faw_q[TFAW-2:0], act_acc};
      if (bus.ref_valid) begin
         out_valid_d = 1'b1;
         out_a_d     = bus.ref_a;
         out_ba_d    = '0;
         out_cas_d   = bus.ref_cas;
         out_ras_d   = bus.ref_ras;
         out_we_d    = bus.ref_we;
      end else if (bank_acc) begin
         out_valid_d    = 1'b1;
         out_a_d        = sel_a;
         out_ba_d       = grant_idx;
         out_cas_d      = sel_cas;
         out_ras_d      = sel_ras;
         out_we_d       = sel_we;
         out_is_read_d  = sel_rd;
         out_is_write_d = sel_wr;
         rr_ptr_d       = (grant_idx == BABITS'(NBANKS - 1)) ? '0 : grant_idx + 1'b1;
      end
      if (act_acc) begin
         trrd_d = TRRD_W'(TRRD - 1);
      end
   end

   // State register; reset clears the slot to NOP immediately along with all
   // arbitration and timing state.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         out_valid_q    <= 1'b0;
         out_a_q        <= '0;
         out_ba_q       <= '0;
         out_cas_q      <= 1'b0;
         out_ras_q      <= 1'b0;
         out_we_q       <= 1'b0;
         out_is_read_q  <= 1'b0;
         out_is_write_q <= 1'b0;
         rr_ptr_q       <= '0;
         trrd_q         <= '0;
         faw_q          <= '0;
      end else begin
         out_valid_q    <= out_valid_d;
         out_a_q        <= out_a_d;
         out_ba_q       <= out_ba_d;
         out_cas_q      <= out_cas_d;
         out_ras_q      <= out_ras_d;
         out_we_q       <= out_we_d;
         out_is_read_q  <= out_is_read_d;
         out_is_write_q <= out_is_write_d;
         rr_ptr_q       <= rr_ptr_d;
         trrd_q         <= trrd_d;
         faw_q          <= faw_d;
      end
   end

   assign bus.out_valid    = out_valid_q;
   assign bus.out_a        = out_a_q;
   assign bus.out_ba       = out_ba_q;
   assign bus.out_cas      = out_cas_q;
   assign bus.out_ras      = out_ras_q;
   assign bus.out_we       = out_we_q;
   assign bus.out_is_read  = out_is_read_q;
   assign bus.out_is_write = out_is_write_q;

endmodule

// File: tb/tb_bank_cmd_arbiter.sv
// Testbench for bank_cmd_arbiter. Two instances share one stimulus: dut_a
// runs the default timing (TRRD=2, TFAW=8) and dut_b runs TRRD=1, TFAW=8 so
// the four-activate window can be seen without tRRD in the way.
module tb_bank_cmd_arbiter;
   import bank_cmd_arbiter_pkg::*;

   localparam int NB = 8;
   localparam int AB = 14;
   localparam int BB = 3;
   localparam logic [AB-1:0] REF_ADDR = 14'h0400;

   logic clk;
   logic rst;

   logic [NB-1:0]    drv_valid, drv_cas, drv_ras, drv_we;
   logic [NB-1:0]    drv_is_cmd, drv_is_read, drv_is_write;
   logic [NB*AB-1:0] drv_a;
   logic             drv_ref_valid;

   int checks;
   int errors;

   typedef struct {
      logic          do_reset;
      logic [NB-1:0] valid;
      logic [NB-1:0] act;
      logic          refv;
      logic [NB-1:0] exp_ready;
      logic          exp_ref_ready;
      logic          exp_out_valid;
      logic [BB-1:0] exp_ba;
      logic [2:0]    exp_cmd;
      string         name;
   } vec_t;

   vec_t vecs[$];

   bank_cmd_arbiter_if #(.NBANKS(NB), .ABITS(AB), .BABITS(BB)) bus_a ();
   bank_cmd_arbiter_if #(.NBANKS(NB), .ABITS(AB), .BABITS(BB)) bus_b ();

   bank_cmd_arbiter #(.NBANKS(NB), .ABITS(AB), .BABITS(BB), .TRRD(2), .TFAW(8)) dut_a (
      .sys_clk (clk),
      .sys_rst (rst),
      .bus     (bus_a.slave)
   );

   bank_cmd_arbiter #(.NBANKS(NB), .ABITS(AB), .BABITS(BB), .TRRD(1), .TFAW(8)) dut_b (
      .sys_clk (clk),
      .sys_rst (rst),
      .bus     (bus_b.slave)
   );

   assign bus_a.bm_valid    = drv_valid;
   assign bus_a.bm_a        = drv_a;
   assign bus_a.bm_cas      = drv_cas;
   assign bus_a.bm_ras      = drv_ras;
   assign bus_a.bm_we       = drv_we;
   assign bus_a.bm_is_cmd   = drv_is_cmd;
   assign bus_a.bm_is_read  = drv_is_read;
   assign bus_a.bm_is_write = drv_is_write;
   assign bus_a.ref_valid   = drv_ref_valid;
   assign bus_a.ref_a       = REF_ADDR;
   assign bus_a.ref_cas     = 1'b1;
   assign bus_a.ref_ras     = 1'b1;
   assign bus_a.ref_we      = 1'b0;

   assign bus_b.bm_valid    = drv_valid;
   assign bus_b.bm_a        = drv_a;
   assign bus_b.bm_cas      = drv_cas;
   assign bus_b.bm_ras      = drv_ras;
   assign bus_b.bm_we       = drv_we;
   assign bus_b.bm_is_cmd   = drv_is_cmd;
   assign bus_b.bm_is_read  = drv_is_read;
   assign bus_b.bm_is_write = drv_is_write;
   assign bus_b.ref_valid   = drv_ref_valid;
   assign bus_b.ref_a       = REF_ADDR;
   assign bus_b.ref_cas     = 1'b1;
   assign bus_b.ref_ras     = 1'b1;
   assign bus_b.ref_we      = 1'b0;

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Bank i always presents address 0x100+i, so the slot address identifies
   // which bank's fields were captured.
   function automatic logic [AB-1:0] bankAddr(input int i);
      return AB'(14'h0100 + i);
   endfunction

   // Drive the bank requests: banks set in act present an ACTIVATE, the other
   // valid banks present a READ.
   task automatic applyStimulus(input logic [NB-1:0] valid, input logic [NB-1:0] act,
                                input logic refv);
      drv_valid     = valid;
      drv_ref_valid = refv;
      for (int i = 0; i < NB; i++) begin
         drv_ras[i]      = act[i];
         drv_cas[i]      = ~act[i];
         drv_we[i]       = 1'b0;
         drv_is_cmd[i]   = act[i];
         drv_is_read[i]  = ~act[i];
         drv_is_write[i] = 1'b0;
      end
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Pulse reset for one cycle and return just after a rising edge with all
   // inputs idle.
   task automatic resetDut();
      applyStimulus('0, '0, 1'b0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   function automatic vec_t mk(input logic do_reset, input logic [NB-1:0] valid,
                               input logic [NB-1:0] act, input logic refv,
                               input logic [NB-1:0] exp_ready, input logic exp_ref_ready,
                               input logic exp_out_valid, input logic [BB-1:0] exp_ba,
                               input logic [2:0] exp_cmd, input string name);
      vec_t v;
      v.do_reset      = do_reset;
      v.valid         = valid;
      v.act           = act;
      v.refv          = refv;
      v.exp_ready     = exp_ready;
      v.exp_ref_ready = exp_ref_ready;
      v.exp_out_valid = exp_out_valid;
      v.exp_ba        = exp_ba;
      v.exp_cmd       = exp_cmd;
      v.name          = name;
      return v;
   endfunction

   initial begin
      logic [AB-1:0] exp_a;
      logic [NB-1:0] pending;
      logic [NB-1:0] exp_rdy;
      int            accept_at[6];
      int            hit;

      checks = 0;
      errors = 0;
      rst    = 1'b1;
      exp_a  = '0;
      for (int i = 0; i < NB; i++) begin
         drv_a[i*AB +: AB] = bankAddr(i);
      end
      applyStimulus('0, '0, 1'b0);

      // Round robin: all banks reading, 16 cycles, two full laps, then idle.
      for (int k = 0; k < 16; k++) begin
         vecs.push_back(mk(k == 0, 8'hFF, 8'h00, 1'b0, NB'(1) << (k % NB), 1'b0,
                           1'b1, BB'(k % NB), CMD_RD, "rr"));
      end
      vecs.push_back(mk(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 3'd7, CMD_NOP, "idle"));
      // tRRD=2: bank0 ACT at cycle 0, nothing at cycle 1, bank1 ACT at cycle 2.
      vecs.push_back(mk(1'b1, 8'h03, 8'h03, 1'b0, 8'h01, 1'b0, 1'b1, 3'd0, CMD_ACT, "trrd_c0"));
      vecs.push_back(mk(1'b0, 8'h02, 8'h02, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, CMD_NOP, "trrd_c1"));
      vecs.push_back(mk(1'b0, 8'h02, 8'h02, 1'b0, 8'h02, 1'b0, 1'b1, 3'd1, CMD_ACT, "trrd_c2"));
      // Refresher beats bank2 in the same cycle; bank2 follows.
      vecs.push_back(mk(1'b1, 8'h04, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 3'd0, CMD_REF, "prio_ref"));
      vecs.push_back(mk(1'b0, 8'h04, 8'h00, 1'b0, 8'h04, 1'b0, 1'b1, 3'd2, CMD_RD, "prio_bank"));
      // Skip: bank7 ACT wraps pointer to 0, bank0 ACT then blocked by tRRD,
      // bank1 READ taken instead, pointer moves on to 2.
      vecs.push_back(mk(1'b1, 8'h80, 8'h80, 1'b0, 8'h80, 1'b0, 1'b1, 3'd7, CMD_ACT, "skip_act7"));
      vecs.push_back(mk(1'b0, 8'h03, 8'h01, 1'b0, 8'h02, 1'b0, 1'b1, 3'd1, CMD_RD, "skip_b1"));
      vecs.push_back(mk(1'b0, 8'h07, 8'h00, 1'b0, 8'h04, 1'b0, 1'b1, 3'd2, CMD_RD, "skip_ptr2"));
      vecs.push_back(mk(1'b0, 8'h03, 8'h01, 1'b0, 8'h01, 1'b0, 1'b1, 3'd0, CMD_ACT, "skip_wrap0"));

      // Reset state, then reset asserted mid-burst between clock edges.
      resetDut();
      #1;
      checkOutput("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
      checkOutput("rst_out_ba", 32'(bus_a.out_ba), 32'd0);
      checkOutput("rst_out_a", 32'(bus_a.out_a), 32'd0);
      checkOutput("rst_ready", 32'(bus_a.bm_ready), 32'd0);
      applyStimulus(8'hFF, 8'h00, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("burst_out_valid", 32'(bus_a.out_valid), 32'd1);
      #2 rst = 1'b1;
      #1;
      checkOutput("async_out_valid", 32'(bus_a.out_valid), 32'd0);
      checkOutput("async_out_cmd", 32'({bus_a.out_cas, bus_a.out_ras, bus_a.out_we}), 32'd0);
      checkOutput("async_out_a", 32'(bus_a.out_a), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Table-driven vectors on dut_a.
      foreach (vecs[n]) begin
         if (vecs[n].do_reset) begin
            resetDut();
         end
         applyStimulus(vecs[n].valid, vecs[n].act, vecs[n].refv);
         #2;
         checkOutput({vecs[n].name, "_ready"}, 32'(bus_a.bm_ready), 32'(vecs[n].exp_ready));
         checkOutput({vecs[n].name, "_ref_ready"}, 32'(bus_a.ref_ready),
                     32'(vecs[n].exp_ref_ready));
         @(posedge clk);
         #1;
         if (vecs[n].exp_out_valid) begin
            exp_a = (vecs[n].exp_cmd == CMD_REF) ? REF_ADDR : bankAddr(int'(vecs[n].exp_ba));
         end
         checkOutput({vecs[n].name, "_out_valid"}, 32'(bus_a.out_valid),
                     32'(vecs[n].exp_out_valid));
         checkOutput({vecs[n].name, "_out_ba"}, 32'(bus_a.out_ba), 32'(vecs[n].exp_ba));
         checkOutput({vecs[n].name, "_out_cmd"},
                     32'({bus_a.out_cas, bus_a.out_ras, bus_a.out_we}), 32'(vecs[n].exp_cmd));
         checkOutput({vecs[n].name, "_out_a"}, 32'(bus_a.out_a), 32'(exp_a));
         checkOutput({vecs[n].name, "_out_rd"}, 32'(bus_a.out_is_read),
                     32'(vecs[n].exp_cmd == CMD_RD));
      end

      // tFAW on dut_b: banks 0..5 all want to ACT. Four go in cycles 0-3,
      // the fifth waits for the window until cycle 8, the sixth follows at 9.
      accept_at = '{0, 1, 2, 3, 8, 9};
      resetDut();
      pending = 8'h3F;
      for (int c = 0; c < 12; c++) begin
         applyStimulus(pending, pending, 1'b0);
         hit = -1;
         for (int n = 0; n < 6; n++) begin
            if (accept_at[n] == c) begin
               hit = n;
            end
         end
         exp_rdy = (hit >= 0) ? NB'(1) << hit : '0;
         #2;
         checkOutput($sformatf("faw_c%0d_ready", c), 32'(bus_b.bm_ready), 32'(exp_rdy));
         @(posedge clk);
         #1;
         checkOutput($sformatf("faw_c%0d_out_valid", c), 32'(bus_b.out_valid),
                     32'(hit >= 0));
         if (hit >= 0) begin
            checkOutput($sformatf("faw_c%0d_out_ba", c), 32'(bus_b.out_ba), 32'(hit));
            checkOutput($sformatf("faw_c%0d_out_cmd", c),
                        32'({bus_b.out_cas, bus_b.out_ras, bus_b.out_we}), 32'(CMD_ACT));
         end
         pending = pending & ~exp_rdy;
      end

      applyStimulus('0, '0, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
